// File: rtl/alu_result_fifo.sv
// ---------------------------------------------------------------------------
// alu_result_fifo
//   First-word-fall-through queue that sits behind the 32-bit ALU. Each entry
//   holds {result, overflow, cout, zero, tag}. The head entry is presented to
//   the writeback stage over a valid/ready handshake. A sticky overflow bit
//   records that some accepted entry carried overflow=1.
//
//   Optional feature (macro ALU_RESULT_FIFO_STATS_EN): adds a 16-bit
//   saturating count of accepted overflow pushes on port ovf_events.
//
// Ports:
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   flush           synchronous queue clear (sticky_ovf is kept)
//   in_valid/ready  producer handshake; in_result/zero/cout/overflow/tag data
//   out_valid/ready consumer handshake; out_result/flags/tag head entry
//                   (out_flags = {overflow, cout, zero})
//   count           occupancy 0..DEPTH
//   sticky_ovf      set by an overflow push, cleared by clr_sticky
//   ovf_events      (stats build only) saturating overflow-push counter
// ---------------------------------------------------------------------------
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_result,
    input  logic             in_zero,
    input  logic             in_cout,
    input  logic             in_overflow,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [2:0]       out_flags,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] count,
    output logic             sticky_ovf,
`ifdef ALU_RESULT_FIFO_STATS_EN
    output logic [15:0]      ovf_events,
`endif
    input  logic             clr_sticky
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      res_q [DEPTH];
    logic [2:0]       flg_q [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic             push, pop;

    // in_ready depends only on registered occupancy plus flush/reset, so the
    // producer never sees a combinational path from out_ready. A full queue
    // therefore refuses a push even in a cycle where the head is popped.
    assign in_ready   = rst_n && (cnt_q != CNT_W'(DEPTH)) && !flush;
    assign out_valid  = (cnt_q != '0);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;

    assign out_result = res_q[rd_ptr_q];
    assign out_flags  = flg_q[rd_ptr_q];
    assign out_tag    = tag_q[rd_ptr_q];
    assign count      = cnt_q;
    assign sticky_ovf = sticky_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            // A pop presented alongside flush is discarded; push is already
            // blocked through in_ready.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the wrap.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Set has priority over clear so a same-cycle overflow is never lost.
    always_comb begin
        sticky_d = sticky_q;
        if (push && in_overflow) sticky_d = 1'b1;
        else if (clr_sticky)     sticky_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                res_q[i] <= '0;
                flg_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            if (push) begin
                res_q[wr_ptr_q] <= in_result;
                flg_q[wr_ptr_q] <= {in_overflow, in_cout, in_zero};
                tag_q[wr_ptr_q] <= in_tag;
            end
        end
    end

`ifdef ALU_RESULT_FIFO_STATS_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (push && in_overflow && (ovf_cnt_q != 16'hFFFF))
            ovf_cnt_d = ovf_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ovf_cnt_q <= '0;
        else        ovf_cnt_q <= ovf_cnt_d;
    end

    assign ovf_events = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n, flush, in_valid, in_ready;
    logic [31:0]      in_result, out_result;
    logic             in_zero, in_cout, in_overflow;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic             out_valid, out_ready, sticky_ovf, clr_sticky;
    logic [2:0]       out_flags;
    logic [CNT_W-1:0] count;
`ifdef ALU_RESULT_FIFO_STATS_EN
    logic [15:0]      ovf_events;
`endif

    always #5 clk = ~clk;

    alu_result_fifo #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_zero(in_zero), .in_cout(in_cout), .in_overflow(in_overflow),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags), .out_tag(out_tag),
        .count(count), .sticky_ovf(sticky_ovf),
`ifdef ALU_RESULT_FIFO_STATS_EN
        .ovf_events(ovf_events),
`endif
        .clr_sticky(clr_sticky)
    );

    // Reference model: a plain queue of entries plus sticky/stat scalars.
    typedef struct packed {
        logic [31:0]      r;
        logic [2:0]       f;
        logic [TAG_W-1:0] t;
    } ent_t;

    ent_t mq[$];
    bit   m_sticky;
    int   m_ovf;
    bit   pristine;   // no push since last reset: storage is all zero
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("in_ready", 64'(in_ready), 64'(rst_n && mq.size() != DEPTH && !flush));
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("count", 64'(count), 64'(mq.size()));
        chk("sticky_ovf", 64'(sticky_ovf), 64'(m_sticky));
        if (mq.size() != 0) begin
            chk("out_result", 64'(out_result), 64'(mq[0].r));
            chk("out_flags", 64'(out_flags), 64'(mq[0].f));
            chk("out_tag", 64'(out_tag), 64'(mq[0].t));
        end else if (pristine) begin
            chk("reset_result", 64'(out_result), 64'd0);
            chk("reset_flags", 64'(out_flags), 64'd0);
            chk("reset_tag", 64'(out_tag), 64'd0);
        end
`ifdef ALU_RESULT_FIFO_STATS_EN
        chk("ovf_events", 64'(ovf_events), 64'(m_ovf));
`endif
    endtask

    // Check current outputs, then advance one clock and update the model from
    // the inputs that were presented at that edge.
    task automatic step(input bit do_chk = 1'b1);
        bit push, pop;
        #1;
        if (do_chk) check_model();
        push = rst_n && in_valid && (mq.size() != DEPTH) && !flush;
        pop  = (mq.size() != 0) && out_ready;
        @(posedge clk);
        if (!rst_n) begin
            mq.delete();
            m_sticky = 0;
            m_ovf    = 0;
            pristine = 1;
        end else begin
            if (flush) mq.delete();
            else begin
                if (pop) void'(mq.pop_front());
                if (push) begin
                    mq.push_back('{r: in_result, f: {in_overflow, in_cout, in_zero}, t: in_tag});
                    pristine = 0;
                end
            end
            if (push && in_overflow) begin
                m_sticky = 1;
                if (m_ovf < 65535) m_ovf++;
            end else if (clr_sticky) m_sticky = 0;
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; in_result = '0; in_zero = 0; in_cout = 0;
        in_overflow = 0; in_tag = '0; out_ready = 0; clr_sticky = 0;
    endtask

    task automatic set_push(input logic [31:0] r, input logic [2:0] f, input logic [TAG_W-1:0] t);
        in_valid = 1; in_result = r; {in_overflow, in_cout, in_zero} = f; in_tag = t;
    endtask

    task automatic drain();
        in_valid = 0; out_ready = 1;
        for (int k = 0; k < 8 && mq.size() != 0; k++) step();
        out_ready = 0;
    endtask

    initial begin
        bit sticky_before;
        idle_inputs();
        rst_n = 0;
        step(1'b0);
        step();
        rst_n = 1;
        // Reset then idle.
        #1;
        chk("lit_reset_count", 64'(count), 64'd0);
        chk("lit_reset_ovalid", 64'(out_valid), 64'd0);
        chk("lit_reset_iready", 64'(in_ready), 64'd1);
        chk("lit_reset_sticky", 64'(sticky_ovf), 64'd0);
        chk("lit_reset_result", 64'(out_result), 64'd0);
        step();

        // Single push into empty queue, then pop.
        set_push(32'h0000_0005, 3'b000, 4'd3);
        step();
        in_valid = 0;
        chk("lit_single_valid", 64'(out_valid), 64'd1);
        chk("lit_single_result", 64'(out_result), 64'h5);
        chk("lit_single_tag", 64'(out_tag), 64'd3);
        out_ready = 1;
        step();
        out_ready = 0;
        chk("lit_single_count", 64'(count), 64'd0);

        // Overfill and drain three times to exercise pointer wrap.
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 1; i <= 5; i++) begin
                set_push(32'(i), 3'(i), 4'(i + rep));
                step();
                if (i == 4) chk("lit_full_iready", 64'(in_ready), 64'd0);
            end
            in_valid = 0;
            chk("lit_full_count", 64'(count), 64'd4);
            out_ready = 1;
            for (int k = 1; k <= 4; k++) begin
                chk("lit_drain_order", 64'(out_result), 64'(k));
                step();
            end
            out_ready = 0;
            chk("lit_drain_empty", 64'(count), 64'd0);
        end

        // Steady push+pop at count=2.
        set_push(32'hA0, 3'b001, 4'd1); step();
        set_push(32'hA1, 3'b010, 4'd2); step();
        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            set_push(32'h100 + 32'(i), 3'(i), 4'(i));
            step();
            chk("lit_stream_count", 64'(count), 64'd2);
        end
        drain();

        // Sticky set wins over same-cycle clear, then clear.
        set_push(32'h8000_0000, 3'b100, 4'd7);
        clr_sticky = 1;
        step();
        in_valid = 0;
        chk("lit_sticky_set", 64'(sticky_ovf), 64'd1);
        step();
        clr_sticky = 0;
        chk("lit_sticky_clr", 64'(sticky_ovf), 64'd0);
        drain();

        // Flush with a concurrent push.
        set_push(32'h8, 3'b100, 4'd1); step();
        set_push(32'h9, 3'b000, 4'd2); step();
        set_push(32'hA, 3'b000, 4'd3); step();
        sticky_before = sticky_ovf;
        flush = 1;
        set_push(32'hDEAD, 3'b000, 4'd4);
        step();
        flush = 0; in_valid = 0;
        chk("lit_flush_count", 64'(count), 64'd0);
        chk("lit_flush_valid", 64'(out_valid), 64'd0);
        chk("lit_flush_sticky", 64'(sticky_ovf), 64'(sticky_before));
        chk("lit_flush_sticky_one", 64'(sticky_ovf), 64'd1);
        step();

`ifdef ALU_RESULT_FIFO_STATS_EN
        rst_n = 0; step(); rst_n = 1;
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            set_push(32'(i), 3'b100, 4'(i));
            step();
        end
        in_valid = 0;
        chk("lit_ovf_events", 64'(ovf_events), 64'd3);
        drain();
`endif

        // Randomized traffic with occasional flush, clear and reset.
        for (int c = 0; c < 3000; c++) begin
            rst_n       = ($urandom_range(0, 199) != 0);
            flush       = ($urandom_range(0, 19) == 0);
            clr_sticky  = ($urandom_range(0, 9) == 0);
            in_valid    = ($urandom_range(0, 2) != 0);
            in_result   = $urandom;
            in_zero     = 1'($urandom);
            in_cout     = 1'($urandom);
            in_overflow = ($urandom_range(0, 3) == 0);
            in_tag      = TAG_W'($urandom);
            out_ready   = ($urandom_range(0, 2) != 0);
            step();
        end
        idle_inputs();
        rst_n = 1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
